dma_regfile: RTL

DMA_REGFILE -- requirements
Module: dma_regfile

---
 rtl/dma_regfile.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_regfile.sv
// DMA channel register file: byte-serial CPU access to per-channel base/current
// address and count registers, plus command, mode, mask, request and status.
module dma_regfile #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  ior_n,
  input  logic                  iow_n,
  input  logic [3:0]            addr_lo,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic                  xfer_upd,
  input  logic [1:0]            xfer_ch,
  input  logic                  eop_in,
  output logic [7:0]            cmd_o,
  output logic [6*NUM_CH-1:0]   mode_o,
  output logic [NUM_CH-1:0]     mask_o,
  output logic [NUM_CH-1:0]     sw_req_o,
  output logic [NUM_CH-1:0]     tc_o,
  output logic [ADDR_W-1:0]     cur_addr_o,
  output logic [CNT_W-1:0]      cur_cnt_o
);

  localparam int MAX_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam int NB    = (MAX_W + 7) / 8;

  logic [ADDR_W-1:0] base_addr [NUM_CH];
  logic [ADDR_W-1:0] cur_addr  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt   [NUM_CH];
  logic [5:0]        mode      [NUM_CH];
  logic [ADDR_W-1:0] base_addr_n [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_n  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_n  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_n   [NUM_CH];
  logic [5:0]        mode_n      [NUM_CH];

  logic [NUM_CH-1:0] mask, sw_req, tc_flag, tc_q;
  logic [NUM_CH-1:0] mask_n, sw_req_n, tc_flag_n, tc_set, mask_set;
  logic [7:0]        cmd, temp, cmd_n, temp_n, dout_n;
  logic [1:0]        bptr, bptr_n;
  logic              ior_q, iow_q;
  logic              rd_ev, wr_ev, chan_ev, acc_ok, xfer_ok, din_ok, tc_clr, mclr;
  logic [1:0]        acc_ch;
  logic [3:0]        sw_pad, tc_pad;

  // A new access needs a high-to-low strobe transition; both strobes low is illegal.
  assign rd_ev   = !cs_n && !ior_n && ior_q && iow_n;
  assign wr_ev   = !cs_n && !iow_n && iow_q && ior_n;
  assign chan_ev = (rd_ev || wr_ev) && !addr_lo[3];
  assign acc_ch  = addr_lo[2:1];
  assign acc_ok  = int'(acc_ch) < NUM_CH;
  assign xfer_ok = int'(xfer_ch) < NUM_CH;
  assign din_ok  = int'(din[1:0]) < NUM_CH;

  function automatic logic [ADDR_W-1:0] put_a(input logic [ADDR_W-1:0] r,
                                              input logic [1:0] p, input logic [7:0] b);
    logic [ADDR_W-1:0] res;
    res = r;
    for (int i = 0; i < ADDR_W; i++)
      if (i / 8 == int'(p)) res[i] = b[i % 8];
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] put_c(input logic [CNT_W-1:0] r,
                                             input logic [1:0] p, input logic [7:0] b);
    logic [CNT_W-1:0] res;
    res = r;
    for (int i = 0; i < CNT_W; i++)
      if (i / 8 == int'(p)) res[i] = b[i % 8];
    return res;
  endfunction

  function automatic logic [7:0] get_a(input logic [ADDR_W-1:0] r, input logic [1:0] p);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (i / 8 == int'(p)) res[i % 8] = r[i];
    return res;
  endfunction

  function automatic logic [7:0] get_c(input logic [CNT_W-1:0] r, input logic [1:0] p);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < CNT_W; i++)
      if (i / 8 == int'(p)) res[i % 8] = r[i];
    return res;
  endfunction

  always_comb begin
    base_addr_n = base_addr;
    cur_addr_n  = cur_addr;
    base_cnt_n  = base_cnt;
    cur_cnt_n   = cur_cnt;
    mode_n      = mode;
    mask_n      = mask;
    sw_req_n    = sw_req;
    cmd_n       = cmd;
    temp_n      = temp;
    bptr_n      = bptr;
    dout_n      = dout;
    tc_set      = '0;
    mask_set    = '0;
    tc_clr      = 1'b0;
    mclr        = 1'b0;
    sw_pad      = '0;
    tc_pad      = '0;
    sw_pad[NUM_CH-1:0] = sw_req;
    tc_pad[NUM_CH-1:0] = tc_flag;

    if (xfer_upd && xfer_ok) begin
      cur_addr_n[xfer_ch] = mode[xfer_ch][3] ? cur_addr[xfer_ch] - 1'b1
                                             : cur_addr[xfer_ch] + 1'b1;
      cur_cnt_n[xfer_ch]  = cur_cnt[xfer_ch] - 1'b1;
      if (cur_cnt[xfer_ch] == '0 || eop_in) begin
        tc_set[xfer_ch] = 1'b1;
        if (mode[xfer_ch][2]) begin
          cur_addr_n[xfer_ch] = base_addr[xfer_ch];
          cur_cnt_n[xfer_ch]  = base_cnt[xfer_ch];
        end else begin
          mask_set[xfer_ch] = 1'b1;
        end
      end
    end

    // CPU byte overrides a same-cycle transfer update of the register it hits.
    if (chan_ev) begin
      bptr_n = (int'(bptr) == NB - 1) ? 2'd0 : bptr + 2'd1;
      if (wr_ev && acc_ok) begin
        if (addr_lo[0]) begin
          base_cnt_n[acc_ch] = put_c(base_cnt[acc_ch], bptr, din);
          cur_cnt_n[acc_ch]  = put_c(cur_cnt[acc_ch], bptr, din);
        end else begin
          base_addr_n[acc_ch] = put_a(base_addr[acc_ch], bptr, din);
          cur_addr_n[acc_ch]  = put_a(cur_addr[acc_ch], bptr, din);
        end
      end
    end

    if (wr_ev) begin
      temp_n = din;
      case (addr_lo)
        4'd8:  cmd_n = din;
        4'd9:  if (din_ok) sw_req_n[din[1:0]] = din[2];
        4'd10: if (din_ok) mask_n[din[1:0]] = din[2];
        4'd11: if (din_ok) mode_n[din[1:0]] = din[7:2];
        4'd12: bptr_n = 2'd0;
        4'd13: mclr = 1'b1;
        4'd14: mask_n = '0;
        4'd15: mask_n = din[NUM_CH-1:0];
        default: ;
      endcase
    end

    if (rd_ev) begin
      if (!addr_lo[3]) begin
        if (!acc_ok)         dout_n = 8'h00;
        else if (addr_lo[0]) dout_n = get_c(cur_cnt[acc_ch], bptr);
        else                 dout_n = get_a(cur_addr[acc_ch], bptr);
      end else begin
        case (addr_lo)
          4'd8: begin
            dout_n = {sw_pad, tc_pad};
            tc_clr = 1'b1;
          end
          4'd13:   dout_n = temp;
          default: dout_n = 8'h00;
        endcase
      end
    end

    mask_n    = mask_n | mask_set;
    sw_req_n  = sw_req_n & ~tc_set;
    tc_flag_n = (tc_clr ? '0 : tc_flag) | tc_set;

    if (mclr) begin
      cmd_n     = '0;
      temp_n    = '0;
      bptr_n    = '0;
      sw_req_n  = '0;
      tc_flag_n = '0;
      mask_n    = '1;
      for (int i = 0; i < NUM_CH; i++) mode_n[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        cur_addr[i]  <= '0;
        base_cnt[i]  <= '0;
        cur_cnt[i]   <= '0;
        mode[i]      <= '0;
      end
      mask    <= '1;
      sw_req  <= '0;
      tc_flag <= '0;
      tc_q    <= '0;
      cmd     <= '0;
      temp    <= '0;
      bptr    <= '0;
      dout    <= '0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
    end else begin
      base_addr <= base_addr_n;
      cur_addr  <= cur_addr_n;
      base_cnt  <= base_cnt_n;
      cur_cnt   <= cur_cnt_n;
      mode      <= mode_n;
      mask      <= mask_n;
      sw_req    <= sw_req_n;
      tc_flag   <= tc_flag_n;
      tc_q      <= tc_set;
      cmd       <= cmd_n;
      temp      <= temp_n;
      bptr      <= bptr_n;
      dout      <= dout_n;
      ior_q     <= ior_n;
      iow_q     <= iow_n;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mode
    assign mode_o[6*g +: 6] = mode[g];
  end

  assign cmd_o      = cmd;
  assign mask_o     = mask;
  assign sw_req_o   = sw_req;
  assign tc_o       = tc_q;
  assign cur_addr_o = xfer_ok ? cur_addr[xfer_ch] : '0;
  assign cur_cnt_o  = xfer_ok ? cur_cnt[xfer_ch] : '0;

endmodule
